// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared types and constants for the period meter.
//   - fm_state_t        : measurement FSM states (IDLE, ARMED, STALLED)
//   - FM_CNT_W_DEF      : default period counter width
//   - FM_MAX_PERIOD_DEF : default stall timeout in clk_in cycles
//   - FM_AVG_DEPTH      : number of periods averaged when FREQ_METER_AVG_EN is defined
//   - FM_AVG_LOG2       : log2 of FM_AVG_DEPTH, used as the averaging shift
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        STALLED = 2'd2
    } fm_state_t;

    localparam int FM_CNT_W_DEF      = 16;
    localparam int FM_MAX_PERIOD_DEF = 60000;
    localparam int FM_AVG_DEPTH      = 4;
    localparam int FM_AVG_LOG2       = 2;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Brings an asynchronous square wave into the clk_in domain through a
//   SYNC_STAGES-deep flop chain, keeps one history flop of the synchronised
//   value and emits a registered single-cycle pulse on each 0->1 transition.
//   Latency from a sig_in transition to rise_pulse is SYNC_STAGES+1 cycles.
// Ports:
//   clk_in     in   system clock
//   reset      in   synchronous, active-high reset
//   sig_in     in   asynchronous input
//   rise_pulse out  one-cycle pulse per detected rising edge
module sync_edge_det
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   hist_p1;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_p0    <= '0;
            hist_p1    <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            // synchroniser stage
            sync_p0    <= {sync_p0[SYNC_STAGES-2:0], sig_in};
            // history / edge stage
            hist_p1    <= sync_p0[SYNC_STAGES-1];
            rise_pulse <= sync_p0[SYNC_STAGES-1] & ~hist_p1;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Measures the period of a slow external square wave in clk_in cycles.
//   Each completed period (rising edge to rising edge) is published on
//   period_out with a one-cycle period_valid strobe. If no edge arrives within
//   MAX_PERIOD cycles the meter enters STALLED and raises stalled; the interval
//   that ends a stall is discarded.
//   Build option FREQ_METER_AVG_EN: period_out becomes the truncated mean of
//   the last 4 periods, and strobes are held back until 4 periods have been
//   collected since IDLE, STALLED or reset.
// Ports:
//   clk_in       in   system clock (sole clock)
//   reset        in   synchronous, active-high reset
//   enable       in   measurement enable; low forces IDLE
//   sig_in       in   asynchronous square wave to measure
//   period_out   out  [CNT_W] last published period
//   period_valid out  one-cycle strobe when period_out updates
//   stalled      out  high while no edge has arrived for MAX_PERIOD cycles
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = FM_CNT_W_DEF,
    parameter int MAX_PERIOD  = FM_MAX_PERIOD_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= MAX_CNT) begin
            return MAX_CNT;
        end
        return v + CNT_ONE;
    endfunction

    logic             rise_p0;
    fm_state_t        state_p0, state_p1;
    logic [CNT_W-1:0] cnt_p0, cnt_p1;
    logic [CNT_W-1:0] period_p0, period_p1;
    logic             vld_p0, vld_p1;
    logic             take_sample;
    logic             clear_hist;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .rise_pulse(rise_p0)
    );

`ifdef FREQ_METER_AVG_EN
    localparam int SUM_W = CNT_W + FM_AVG_LOG2;
    localparam int FILL_W = FM_AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FM_AVG_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    // Mean of the window; truncation is intended.
    function automatic logic [CNT_W-1:0] avg_div(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:FM_AVG_LOG2];
    endfunction

    logic [FM_AVG_DEPTH-1:0][CNT_W-1:0] avg_hist_p0, avg_hist_p1;
    logic [SUM_W-1:0]                   sum_p0, sum_p1;
    logic [FILL_W-1:0]                  fill_p0, fill_p1;
`else
    logic unused_clear_hist;
    assign unused_clear_hist = clear_hist;
`endif

    always_comb begin
        state_p0    = state_p1;
        cnt_p0      = cnt_p1;
        period_p0   = period_p1;
        vld_p0      = 1'b0;
        take_sample = 1'b0;
        clear_hist  = 1'b0;

        if (!enable) begin
            state_p0   = IDLE;
            cnt_p0     = '0;
            clear_hist = 1'b1;
        end else begin
            case (state_p1)
                IDLE: begin
                    cnt_p0     = '0;
                    clear_hist = 1'b1;
                    if (rise_p0) begin
                        state_p0 = ARMED;
                        cnt_p0   = CNT_ONE;
                    end
                end
                ARMED: begin
                    // An edge in the same cycle the counter reaches the
                    // timeout is still a valid period.
                    if (rise_p0) begin
                        take_sample = 1'b1;
                        cnt_p0      = CNT_ONE;
                    end else if (cnt_p1 == MAX_CNT) begin
                        state_p0   = STALLED;
                        clear_hist = 1'b1;
                    end else begin
                        cnt_p0 = sat_inc(cnt_p1);
                    end
                end
                STALLED: begin
                    // The interval ending a stall is not a real period.
                    if (rise_p0) begin
                        state_p0 = ARMED;
                        cnt_p0   = CNT_ONE;
                    end
                end
                default: begin
                    state_p0 = IDLE;
                    cnt_p0   = '0;
                end
            endcase
        end

`ifdef FREQ_METER_AVG_EN
        avg_hist_p0 = avg_hist_p1;
        sum_p0      = sum_p1;
        fill_p0     = fill_p1;
        if (clear_hist) begin
            avg_hist_p0 = '0;
            sum_p0      = '0;
            fill_p0     = '0;
        end else if (take_sample) begin
            // Oldest entry is zero until the window fills, so the running sum
            // stays exact during warm-up.
            avg_hist_p0 = {avg_hist_p1[FM_AVG_DEPTH-2:0], cnt_p1};
            sum_p0      = sum_p1 + SUM_W'(cnt_p1) - SUM_W'(avg_hist_p1[FM_AVG_DEPTH-1]);
            if (fill_p1 != FILL_FULL) begin
                fill_p0 = fill_p1 + FILL_ONE;
            end
            if (fill_p0 == FILL_FULL) begin
                period_p0 = avg_div(sum_p0);
                vld_p0    = 1'b1;
            end
        end
`else
        if (take_sample) begin
            period_p0 = cnt_p1;
            vld_p0    = 1'b1;
        end
`endif
    end

    // state register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_p0;
        end
    end

    // counter / output register stage
    always_ff @(posedge clk_in) begin
        if (reset) begin
            cnt_p1    <= '0;
            period_p1 <= '0;
            vld_p1    <= 1'b0;
        end else begin
            cnt_p1    <= cnt_p0;
            period_p1 <= period_p0;
            vld_p1    <= vld_p0;
        end
    end

`ifdef FREQ_METER_AVG_EN
    // averaging window register stage
    always_ff @(posedge clk_in) begin
        if (reset) begin
            avg_hist_p1 <= '0;
            sum_p1      <= '0;
            fill_p1     <= '0;
        end else begin
            avg_hist_p1 <= avg_hist_p0;
            sum_p1      <= sum_p0;
            fill_p1     <= fill_p0;
        end
    end
`endif

    assign period_out   = period_p1;
    assign period_valid = vld_p1;
    assign stalled      = (state_p1 == STALLED);

endmodule

// File: tb/tb_freq_meter.sv
// Testbench for freq_meter. Timeout is scaled down to 6000 cycles to keep
// the run short; all scenarios are relative to MAX_P.
module tb_freq_meter;

    localparam int CNT_W = 16;
    localparam int MAX_P = 6000;
    localparam int SYNC  = 2;
    localparam int PER   = 940;

    logic             clk_in = 1'b0;
    logic             reset  = 1'b1;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             stalled;

    int tests_run       = 0;
    int tests_failed    = 0;
    int cyc             = 0;
    int strobe_cnt      = 0;
    int last_strobe_cyc = 0;
    int prev_strobe_cyc = 0;
    int stall_cycles    = 0;
    int exp_q[$];

    freq_meter #(
        .CNT_W      (CNT_W),
        .MAX_PERIOD (MAX_P),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .enable      (enable),
        .sig_in      (sig_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .stalled     (stalled)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest expected period.
    always @(negedge clk_in) begin
        if (period_valid === 1'b1) begin
            int exp_v;
            strobe_cnt++;
            prev_strobe_cyc = last_strobe_cyc;
            last_strobe_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_strobe: period_out=%0d at cycle %0d, required no strobe", period_out, cyc);
            end else begin
                exp_v = exp_q.pop_front();
                if (period_out !== CNT_W'(exp_v)) begin
                    tests_failed++;
                    $display("FAIL strobe_period: got %0d, required %0d", period_out, exp_v);
                end
            end
        end
        if (stalled === 1'b1) stall_cycles++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // n rising edges spaced per cycles; the first edge expects first_exp
    // (0 = no strobe), the rest expect per. Ends per cycles after last rise.
    task automatic pulses(input int n, input int per, input int first_exp);
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                if (first_exp != 0) exp_q.push_back(first_exp);
            end else begin
                exp_q.push_back(per);
            end
            sig_in = 1'b1;
            tick(per / 2);
            sig_in = 1'b0;
            tick(per - per / 2);
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        tick(3);
        @(negedge clk_in);
        tests_run++;
        if (period_out !== '0) begin
            tests_failed++;
            $display("FAIL reset_period: got %0d, required 0", period_out);
        end
        tests_run++;
        if (period_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b, required 0", period_valid);
        end
        tests_run++;
        if (stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stalled: got %b, required 0", stalled);
        end
        tick(1);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_basic;
        int base;
        enable = 1'b1;
        tick(5);
        base = strobe_cnt;
        pulses(6, PER, 0);
        tests_run++;
        if (strobe_cnt - base !== 5) begin
            tests_failed++;
            $display("FAIL basic_strobe_count: got %0d, required 5", strobe_cnt - base);
        end
        tests_run++;
        if (last_strobe_cyc - prev_strobe_cyc !== PER) begin
            tests_failed++;
            $display("FAIL basic_strobe_spacing: got %0d, required %0d", last_strobe_cyc - prev_strobe_cyc, PER);
        end
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL basic_pending: got %0d outstanding, required 0", exp_q.size());
        end
        tests_run++;
        if (stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_stalled: got %b, required 0", stalled);
        end
    endtask

    task automatic test_stall;
        int base;
        int n;
        base = strobe_cnt;
        n = 0;
        while (stalled !== 1'b1 && n < MAX_P + 2000) begin
            @(negedge clk_in);
            n++;
        end
        tests_run++;
        if (stalled !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_timeout: stalled=%b after %0d cycles, required 1", stalled, n);
        end else if (cyc - last_strobe_cyc !== MAX_P) begin
            tests_failed++;
            $display("FAIL stall_latency: got %0d cycles, required %0d", cyc - last_strobe_cyc, MAX_P);
        end
        tests_run++;
        if (period_out !== CNT_W'(PER)) begin
            tests_failed++;
            $display("FAIL stall_period_kept: got %0d, required %0d", period_out, PER);
        end
        tick(1);
        pulses(1, PER, 0);
        tests_run++;
        if (stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_clear: got %b, required 0", stalled);
        end
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL stall_no_strobe: got %0d strobes, required 0", strobe_cnt - base);
        end
        pulses(2, PER, PER);
        tests_run++;
        if (strobe_cnt - base !== 2 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL stall_recover: got %0d strobes / %0d pending, required 2 / 0", strobe_cnt - base, exp_q.size());
        end
    endtask

    task automatic test_enable;
        int base;
        exp_q.push_back(PER);
        sig_in = 1'b1;
        tick(PER / 2);
        sig_in = 1'b0;
        tick(200);
        enable = 1'b0;
        tick(10);
        tests_run++;
        if (stalled !== 1'b0 || period_out !== CNT_W'(PER)) begin
            tests_failed++;
            $display("FAIL enable_off: stalled=%b period=%0d, required 0 / %0d", stalled, period_out, PER);
        end
        base = strobe_cnt;
        enable = 1'b1;
        tick(PER - PER / 2 - 210);
        pulses(1, PER, 0);
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL enable_first_edge: got %0d strobes, required 0", strobe_cnt - base);
        end
        pulses(2, PER, PER);
        tests_run++;
        if (strobe_cnt - base !== 2 || period_out !== CNT_W'(PER)) begin
            tests_failed++;
            $display("FAIL enable_recover: got %0d strobes period=%0d, required 2 / %0d", strobe_cnt - base, period_out, PER);
        end
    endtask

    task automatic test_reset_mid;
        int base;
        exp_q.push_back(PER);
        sig_in = 1'b1;
        tick(PER / 2);
        sig_in = 1'b0;
        tick(300);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk_in);
        tests_run++;
        if (period_out !== '0 || period_valid !== 1'b0 || stalled !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: period=%0d valid=%b stalled=%b, required 0/0/0", period_out, period_valid, stalled);
        end
        tick(169);
        base = strobe_cnt;
        pulses(3, PER, 0);
        tests_run++;
        if (strobe_cnt - base !== 2 || period_out !== CNT_W'(PER)) begin
            tests_failed++;
            $display("FAIL reset_recover: got %0d strobes period=%0d, required 2 / %0d", strobe_cnt - base, period_out, PER);
        end
    endtask

    task automatic test_edge_at_max;
        int base_stall;
        base_stall = stall_cycles;
        pulses(1, MAX_P, PER);
        pulses(1, PER, MAX_P);
        tests_run++;
        if (stall_cycles !== base_stall) begin
            tests_failed++;
            $display("FAIL max_no_stall: got %0d stalled cycles, required 0", stall_cycles - base_stall);
        end
        tests_run++;
        if (period_out !== CNT_W'(MAX_P) || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL max_period: got %0d (%0d pending), required %0d (0 pending)", period_out, exp_q.size(), MAX_P);
        end
    endtask

`ifdef FREQ_METER_AVG_EN
    task automatic test_avg;
        int base;
        enable = 1'b1;
        tick(5);
        base = strobe_cnt;
        pulses(1, 900, 0);
        pulses(1, 920, 0);
        pulses(1, 960, 0);
        pulses(1, 980, 0);
        tests_run++;
        if (strobe_cnt !== base) begin
            tests_failed++;
            $display("FAIL avg_warmup: got %0d strobes, required 0", strobe_cnt - base);
        end
        pulses(1, 1000, 940);
        pulses(1, PER, 965);
        tests_run++;
        if (strobe_cnt - base !== 2 || period_out !== CNT_W'(965)) begin
            tests_failed++;
            $display("FAIL avg_result: got %0d strobes period=%0d, required 2 / 965", strobe_cnt - base, period_out);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef FREQ_METER_AVG_EN
        test_avg;
`else
        test_basic;
        test_stall;
        test_enable;
        test_reset_mid;
        test_edge_at_max;
`endif
        tests_run++;
        if (exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL missing_strobes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
